// File: rtl/cgra_col_mem_arbiter.sv
// cgra_col_mem_arbiter
// Per-column memory-port arbiter. Serialises the memory requests of N_REQ
// cells sharing one column bus port (fixed priority or round robin), keeps up
// to MAX_OUTST reads in flight in a read-ID FIFO and routes each returned read
// back to its originating row, where it is held until the next instruction.
//
// Ports
//   clk_i, rst_ni              column clock, async active-low reset
//   instr_start_i              one-cycle pulse per instruction, clears served state
//   req_i/wen_i/add_i/wdata_i  per-row request, 1=read, address, write data
//   data_*_o / data_gnt_i      column bus master request side
//   data_rvalid_i/data_rdata_i column bus read return
//   rdata_o/rdata_valid_o      per-row captured read data and valid
//   stall_o/done_o             some requesting row pending / all served
//   err_o                      sticky: read return with no read in flight
module cgra_col_mem_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DP_WIDTH  = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter bit          RR_EN     = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      instr_start_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          wen_i,
  input  logic [N_REQ*DP_WIDTH-1:0] add_i,
  input  logic [N_REQ*DP_WIDTH-1:0] wdata_i,
  output logic                      data_req_o,
  output logic                      data_wen_o,
  output logic [DP_WIDTH-1:0]       data_add_o,
  output logic [DP_WIDTH-1:0]       data_wdata_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic [DP_WIDTH-1:0]       data_rdata_i,
  output logic [N_REQ*DP_WIDTH-1:0] rdata_o,
  output logic [N_REQ-1:0]          rdata_valid_o,
  output logic                      stall_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [N_REQ-1:0]    gnt_done_q, gnt_done_d;
  logic [N_REQ-1:0]    served_q, served_d;
  logic [N_REQ-1:0]    rdata_valid_q, rdata_valid_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                epoch_q, epoch_d;
  logic                err_q, err_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // FIFO entry: {epoch, row}
  logic [SEL_W:0]      fifo_q [MAX_OUTST];
  logic [SEL_W:0]      fifo_d [MAX_OUTST];
  logic [DP_WIDTH-1:0] rdata_q [N_REQ];
  logic [DP_WIDTH-1:0] rdata_d [N_REQ];

  logic [DP_WIDTH-1:0] add_a   [N_REQ];
  logic [DP_WIDTH-1:0] wdata_a [N_REQ];
  logic [N_REQ-1:0]    pending;
  logic [SEL_W-1:0]    sel;
  logic                found;
  logic                fifo_full;
  logic                accept, push, pop;
  logic [SEL_W:0]      head;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      add_a[i]   = add_i[i*DP_WIDTH +: DP_WIDTH];
      wdata_a[i] = wdata_i[i*DP_WIDTH +: DP_WIDTH];
      rdata_o[i*DP_WIDTH +: DP_WIDTH] = rdata_q[i];
    end
  end

  // Round robin searches upward from rr_ptr with wrap; fixed priority from row 0.
  always_comb begin
    pending = req_i & ~gnt_done_q;
    sel     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = RR_EN ? (i + 32'(rr_ptr_q)) % N_REQ : i;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = SEL_W'(idx);
      end
    end
  end

  assign fifo_full = (cnt_q == CNT_W'(MAX_OUTST));

  // Request is held off during instr_start_i so a grant never lands in the
  // cycle where the epoch flips.
  assign data_req_o   = found & ~(fifo_full & wen_i[sel]) & ~instr_start_i;
  assign data_wen_o   = data_req_o & wen_i[sel];
  assign data_add_o   = data_req_o ? add_a[sel] : '0;
  assign data_wdata_o = (data_req_o && !wen_i[sel]) ? wdata_a[sel] : '0;

  assign accept = data_req_o & data_gnt_i;
  assign push   = accept & wen_i[sel];
  assign pop    = data_rvalid_i & (cnt_q != '0);
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    gnt_done_d    = gnt_done_q;
    served_d      = served_q;
    rdata_valid_d = rdata_valid_q;
    rr_ptr_d      = rr_ptr_q;
    epoch_d       = epoch_q;
    err_d         = err_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q + CNT_W'(push) - CNT_W'(pop);
    fifo_d        = fifo_q;
    rdata_d       = rdata_q;

    if (accept) begin
      gnt_done_d[sel] = 1'b1;
      if (wen_i[sel]) begin
        fifo_d[wr_ptr_q] = {epoch_q, sel};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end else begin
        served_d[sel] = 1'b1;
      end
      if (RR_EN) begin
        rr_ptr_d = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + SEL_W'(1);
      end
    end

    // Stale-epoch returns are popped but discarded.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head[SEL_W] == epoch_q && !instr_start_i) begin
        rdata_d[head[SEL_W-1:0]]       = data_rdata_i;
        rdata_valid_d[head[SEL_W-1:0]] = 1'b1;
        served_d[head[SEL_W-1:0]]      = 1'b1;
      end
    end else if (data_rvalid_i) begin
      err_d = 1'b1;
    end

    // FIFO and rdata contents survive; in-flight reads drain as stale.
    if (instr_start_i) begin
      gnt_done_d    = '0;
      served_d      = '0;
      rdata_valid_d = '0;
      epoch_d       = ~epoch_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_done_q    <= '0;
      served_q      <= '0;
      rdata_valid_q <= '0;
      rr_ptr_q      <= '0;
      epoch_q       <= 1'b0;
      err_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) rdata_q[i] <= '0;
    end else begin
      gnt_done_q    <= gnt_done_d;
      served_q      <= served_d;
      rdata_valid_q <= rdata_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      epoch_q       <= epoch_d;
      err_q         <= err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      fifo_q        <= fifo_d;
      rdata_q       <= rdata_d;
    end
  end

  assign rdata_valid_o = rdata_valid_q;
  assign err_o         = err_q;
  assign done_o        = &(~req_i | served_q);
  assign stall_o       = (|req_i) & ~done_o;

endmodule

// File: tb/tb_cgra_col_mem_arbiter.sv
// Testbench for cgra_col_mem_arbiter: two instances (fixed priority with a
// 4-deep read FIFO, round robin with a 2-deep read FIFO) share the cell-side
// stimulus and have their own bus-side grant/return streams. A queue-based
// reference model predicts every output each cycle.
module tb_cgra_col_mem_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               instr_start;
  logic [N-1:0]       req, wen;
  logic [N*W-1:0]     add, wdata;
  logic [1:0]         gnt, rvalid;
  logic [1:0][W-1:0]  rdata_in;

  logic [1:0]         o_req, o_wen, o_stall, o_done, o_err;
  logic [1:0][W-1:0]  o_add, o_wdata;
  logic [1:0][N*W-1:0] o_rdata;
  logic [1:0][N-1:0]  o_rvld;

  cgra_col_mem_arbiter #(.N_REQ(N), .DP_WIDTH(W), .MAX_OUTST(4), .RR_EN(1'b0)) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .instr_start_i(instr_start),
    .req_i(req), .wen_i(wen), .add_i(add), .wdata_i(wdata),
    .data_req_o(o_req[0]), .data_wen_o(o_wen[0]), .data_add_o(o_add[0]),
    .data_wdata_o(o_wdata[0]), .data_gnt_i(gnt[0]), .data_rvalid_i(rvalid[0]),
    .data_rdata_i(rdata_in[0]), .rdata_o(o_rdata[0]), .rdata_valid_o(o_rvld[0]),
    .stall_o(o_stall[0]), .done_o(o_done[0]), .err_o(o_err[0]));

  cgra_col_mem_arbiter #(.N_REQ(N), .DP_WIDTH(W), .MAX_OUTST(2), .RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .instr_start_i(instr_start),
    .req_i(req), .wen_i(wen), .add_i(add), .wdata_i(wdata),
    .data_req_o(o_req[1]), .data_wen_o(o_wen[1]), .data_add_o(o_add[1]),
    .data_wdata_o(o_wdata[1]), .data_gnt_i(gnt[1]), .data_rvalid_i(rvalid[1]),
    .data_rdata_i(rdata_in[1]), .rdata_o(o_rdata[1]), .rdata_valid_o(o_rvld[1]),
    .stall_o(o_stall[1]), .done_o(o_done[1]), .err_o(o_err[1]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model, one slot per instance.
  int       cfg_rr    [2] = '{0, 1};
  int       cfg_depth [2] = '{4, 2};
  bit       m_gd  [2][N];
  bit       m_sv  [2][N];
  bit       m_rv  [2][N];
  logic [W-1:0] m_rd [2][N];
  int       m_rr  [2];
  bit       m_ep  [2];
  bit       m_err [2];
  int       m_fifo[2][$];   // entry = epoch*256 + row
  int       countdown;

  task automatic model_reset(input int k);
    for (int r = 0; r < N; r++) begin
      m_gd[k][r] = 0; m_sv[k][r] = 0; m_rv[k][r] = 0; m_rd[k][r] = '0;
    end
    m_rr[k] = 0; m_ep[k] = 0; m_err[k] = 0;
    m_fifo[k].delete();
  endtask

  task automatic model_comb(input int k, output bit er, output int es);
    es = -1;
    for (int i = 0; i < N; i++) begin
      int r;
      r = (cfg_rr[k] != 0) ? (m_rr[k] + i) % N : i;
      if (es < 0 && req[r] && !m_gd[k][r]) es = r;
    end
    er = (es >= 0) && !instr_start;
    if (er && wen[es] && m_fifo[k].size() >= cfg_depth[k]) er = 0;
  endtask

  task automatic check_outputs(input int k);
    bit er, ew, edone;
    int es;
    logic [W-1:0] ea, ewd;
    model_comb(k, er, es);
    ew = 0; ea = '0; ewd = '0;
    if (er) begin
      ew = wen[es];
      ea = add[es*W +: W];
      if (!wen[es]) ewd = wdata[es*W +: W];
    end
    edone = 1;
    for (int r = 0; r < N; r++) if (req[r] && !m_sv[k][r]) edone = 0;
    check_eq($sformatf("d%0d.data_req", k), o_req[k], er);
    check_eq($sformatf("d%0d.data_wen", k), o_wen[k], ew);
    check_eq($sformatf("d%0d.data_add", k), o_add[k], ea);
    check_eq($sformatf("d%0d.data_wdata", k), o_wdata[k], ewd);
    for (int r = 0; r < N; r++) begin
      check_eq($sformatf("d%0d.rdata_valid[%0d]", k, r), o_rvld[k][r], m_rv[k][r]);
      check_eq($sformatf("d%0d.rdata[%0d]", k, r), o_rdata[k][r*W +: W], m_rd[k][r]);
    end
    check_eq($sformatf("d%0d.done", k), o_done[k], edone);
    check_eq($sformatf("d%0d.stall", k), o_stall[k], (|req) && !edone);
    check_eq($sformatf("d%0d.err", k), o_err[k], m_err[k]);
  endtask

  task automatic model_step(input int k);
    bit er;
    int es, e;
    model_comb(k, er, es);
    if (rvalid[k]) begin
      if (m_fifo[k].size() > 0) begin
        e = m_fifo[k].pop_front();
        if ((e / 256) == int'(m_ep[k]) && !instr_start) begin
          m_rd[k][e % 256] = rdata_in[k];
          m_rv[k][e % 256] = 1;
          m_sv[k][e % 256] = 1;
        end
      end else begin
        m_err[k] = 1;
      end
    end
    if (er && gnt[k]) begin
      m_gd[k][es] = 1;
      if (wen[es]) m_fifo[k].push_back(int'(m_ep[k]) * 256 + es);
      else m_sv[k][es] = 1;
      if (cfg_rr[k] != 0) m_rr[k] = (es + 1) % N;
    end
    if (instr_start) begin
      for (int r = 0; r < N; r++) begin
        m_gd[k][r] = 0; m_sv[k][r] = 0; m_rv[k][r] = 0;
      end
      m_ep[k] = !m_ep[k];
    end
  endtask

  // mode 0: random traffic, 1: no grants and drain reads, 2: forced returns
  task automatic do_cycle(input int mode);
    @(negedge clk);
    if (mode == 0) begin
      if (countdown == 0) begin
        instr_start = 1'b1;
        req = 4'($urandom);
        wen = 4'($urandom);
        for (int r = 0; r < N; r++) begin
          add[r*W +: W]   = {8'(r), 24'($urandom)};
          wdata[r*W +: W] = $urandom;
        end
        countdown = $urandom_range(3, 24);
      end else begin
        instr_start = 1'b0;
        countdown--;
      end
      for (int k = 0; k < 2; k++) begin
        gnt[k]      = ($urandom_range(0, 3) != 0);
        rvalid[k]   = (m_fifo[k].size() > 0) && ($urandom_range(0, 2) == 0);
        rdata_in[k] = $urandom;
      end
    end else begin
      instr_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        gnt[k]      = 1'b0;
        rvalid[k]   = (mode == 2) || (m_fifo[k].size() > 0);
        rdata_in[k] = $urandom;
      end
    end
    #1;
    check_outputs(0);
    check_outputs(1);
    model_step(0);
    model_step(1);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    gnt = '0; rvalid = '0; instr_start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_start = 1'b0;
    req = '0; wen = '0; add = '0; wdata = '0;
    gnt = '0; rvalid = '0; rdata_in = '0;
    model_reset(0);
    model_reset(1);
    countdown = 0;
    repeat (2) @(negedge clk);
    req = 4'b1011;
    wen = 4'b0001;
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      do_cycle(0);
      if (c == 1500) mid_reset();
    end

    repeat (10) do_cycle(1);
    check_eq("drain_fp", m_fifo[0].size(), 0);
    check_eq("drain_rr", m_fifo[1].size(), 0);

    do_cycle(2);
    repeat (3) do_cycle(1);
    check_eq("err_sticky_fp", o_err[0], 1'b1);
    check_eq("err_sticky_rr", o_err[1], 1'b1);

    mid_reset();
    check_eq("err_cleared_fp", o_err[0], 1'b0);
    check_eq("err_cleared_rr", o_err[1], 1'b0);
    repeat (5) do_cycle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
